// File: rtl/alu_op_issuer.sv
// Initiator for the combinational ALU op interface: registers a request's operands onto
// the shared fu bus, waits for the units to settle, then returns the captured result.
module alu_op_issuer #(
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 1   // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [DATA_W-1:0] fu_a,
  output logic [DATA_W-1:0] fu_b,
  input  logic [DATA_W-1:0] and_res,
  input  logic [DATA_W-1:0] or_res,
  input  logic [DATA_W-1:0] xor_res,
  input  logic [DATA_W-1:0] add_res,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_cnt;
  logic [2:0]          r_op;
  logic                r_illegal;
  logic [DATA_W-1:0]   r_fu_a;
  logic [DATA_W-1:0]   r_fu_b;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_zero;
  logic                r_rsp_err;

  logic                w_accept;
  logic                w_op_legal;
  logic                w_capture;
  logic                w_rsp_done;
  logic [DATA_W-1:0]   w_result;

  assign req_ready  = (r_state == S_IDLE) & ~rst;
  assign w_accept   = req_valid & req_ready;
  assign w_op_legal = (req_op <= OP_NOR);
  assign w_capture  = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_rsp_done = (r_state == S_RESP) && rsp_ready;

  // Illegal ops still pass through one WAIT cycle so their response appears
  // one cycle after accept, but the operand settle count is skipped.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept)   w_state_next = S_WAIT;
      S_WAIT: if (w_capture)  w_state_next = S_RESP;
      S_RESP: if (rsp_ready)  w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_result = '0;
    case (r_op)
      OP_AND:  w_result = and_res;
      OP_OR:   w_result = or_res;
      OP_XOR:  w_result = xor_res;
      OP_ADD:  w_result = add_res;
      OP_NOR:  w_result = ~or_res;
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_op        <= 3'd0;
      r_illegal   <= 1'b0;
      r_fu_a      <= '0;
      r_fu_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (w_accept) begin
        r_fu_a    <= req_a;
        r_fu_b    <= req_b;
        r_op      <= req_op;
        r_illegal <= ~w_op_legal;
        r_cnt     <= w_op_legal ? CNT_LOAD : 4'd0;
        if (!w_op_legal) begin
          r_rsp_data <= '0;
          r_rsp_zero <= 1'b1;
          r_rsp_err  <= 1'b1;
        end
      end

      if (r_state == S_WAIT) begin
        if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_rsp_valid <= 1'b1;
          if (!r_illegal) begin
            r_rsp_data <= w_result;
            r_rsp_zero <= (w_result == '0);
            r_rsp_err  <= 1'b0;
          end
        end
      end

      if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign fu_a      = r_fu_a;
  assign fu_b      = r_fu_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_zero  = r_rsp_zero;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: table of ALU requests checked through a response scoreboard,
// plus hand-written reset, backpressure and reset-during-wait sequences.
module tb_alu_op_issuer;

  localparam int DATA_W = 32;
  localparam int SETTLE = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [DATA_W-1:0] fu_a;
  logic [DATA_W-1:0] fu_b;
  logic [DATA_W-1:0] and_res;
  logic [DATA_W-1:0] or_res;
  logic [DATA_W-1:0] xor_res;
  logic [DATA_W-1:0] add_res;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;
  logic              rsp_err;

  alu_op_issuer #(.DATA_W(DATA_W), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .fu_a(fu_a), .fu_b(fu_b),
    .and_res(and_res), .or_res(or_res), .xor_res(xor_res), .add_res(add_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // Combinational functional units on the shared operand bus
  assign and_res = fu_a & fu_b;
  assign or_res  = fu_a | fu_b;
  assign xor_res = fu_a ^ fu_b;
  assign add_res = fu_a + fu_b;

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] exp_data;
    logic              exp_zero;
    logic              exp_err;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              zero;
    logic              err;
  } rsp_t;

  int   checks = 0;
  int   errors = 0;
  int   n_rsp  = 0;
  rsp_t sb_q[$];
  vec_t vecs[12];

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: one pop per response handshake
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      rsp_t e;
      n_rsp++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got data %h with no response expected", rsp_data);
      end else begin
        e = sb_q.pop_front();
        $display("rsp %0d: data=%h zero=%0b err=%0b (exp %h %0b %0b)",
                 n_rsp, rsp_data, rsp_zero, rsp_err, e.data, e.zero, e.err);
        check("rsp_data", rsp_data, e.data);
        check("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
        check("rsp_err",  {31'd0, rsp_err},  {31'd0, e.err});
      end
    end
  end

  // Drive one request and return once it has been accepted (1 after the accept edge)
  task automatic accept_req(input logic [2:0] op, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] b);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("fu_a", fu_a, a);
    check("fu_b", fu_b, b);
  endtask

  // Count cycles from accept until rsp_valid rises
  task automatic wait_valid(input int exp_lat);
    int n = 0;
    while (!rsp_valid && n < 40) begin
      if (n > 0) check("req_ready_busy", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1; n++;
    end
    check("latency", n, exp_lat);
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] d, input logic z, input logic e);
    rsp_t r;
    r.data = d; r.zero = z; r.err = e;
    sb_q.push_back(r);
  endtask

  initial begin
    int seen;
    vecs[0]  = '{3'b000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1'b0};
    vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2]  = '{3'b100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[3]  = '{3'b001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0};
    vecs[4]  = '{3'b010, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5]  = '{3'b010, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1'b0, 1'b0};
    vecs[6]  = '{3'b011, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0};
    vecs[7]  = '{3'b110, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1};
    vecs[8]  = '{3'b100, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0};
    vecs[9]  = '{3'b101, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1'b1, 1'b1};
    vecs[10] = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[11] = '{3'b111, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};

    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0; rsp_ready = 1'b1;

    // Reset: two cycles, outputs cleared and req_ready low throughout
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_fu_a", fu_a, 32'd0);
      check("rst_fu_b", fu_b, 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_flags", {30'd0, rsp_zero, rsp_err}, 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Table-driven requests with rsp_ready held high
    for (int i = 0; i < 12; i++) begin
      $display("req %0d: op=%b a=%h b=%h", i, vecs[i].op, vecs[i].a, vecs[i].b);
      push_exp(vecs[i].exp_data, vecs[i].exp_zero, vecs[i].exp_err);
      accept_req(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(vecs[i].exp_err ? 1 : SETTLE);
      @(posedge clk); #1;
      check("rsp_cleared", {31'd0, rsp_valid}, 32'd0);
    end

    // Backpressure: response held for 5 cycles, new request refused
    rsp_ready = 1'b0;
    $display("req bp: op=001 a=0000f000 b=0000000f");
    push_exp(32'h0000_F00F, 1'b0, 1'b0);
    accept_req(3'b001, 32'h0000_F000, 32'h0000_000F);
    wait_valid(SETTLE);
    req_valid = 1'b1; req_op = 3'b011; req_a = 32'h5555_5555; req_b = 32'h1;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_data", rsp_data, 32'h0000_F00F);
      check("bp_ready", {31'd0, req_ready}, 32'd0);
      check("bp_fu_a", fu_a, 32'h0000_F000);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    check("bp_release_ready", {31'd0, req_ready}, 32'd1);

    // Reset in the middle of WAIT: request must vanish without a response
    $display("req abort: op=011 a=00000003 b=00000004");
    accept_req(3'b011, 32'h0000_0003, 32'h0000_0004);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check("abort_no_rsp", seen, 0);
    check("abort_fu_a", fu_a, 32'd0);

    $display("req fresh: op=011 a=00000003 b=00000004");
    push_exp(32'h0000_0007, 1'b0, 1'b0);
    accept_req(3'b011, 32'h0000_0003, 32'h0000_0004);
    wait_valid(SETTLE);
    @(posedge clk); #1;
    check("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
